// File: rtl/cmd_fetch_pkg.sv
// Shared types and constants for the cmd_fetch command front end.
// Header layout: bit31 = payload follows, [15:8] = len/arg, [7:0] = opcode.
package cmd_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CMD,
    PAY,
    HALT,
    ERR
  } state_t;

  localparam int HDR_PAYLOAD_BIT = 31;
  localparam int FIELD_MSB       = 15;
  localparam int FIELD_LSB       = 8;
  localparam int OPCODE_MSB      = 7;
  localparam int OPCODE_LSB      = 0;

  localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
  localparam logic [7:0] OP_MULT_MATRIX = 8'h11;
  localparam logic [7:0] OP_VERTEX      = 8'h03;
  localparam logic [7:0] OP_COLOR       = 8'h04;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  // Payload window width in words (read1..read4).
  localparam int BEAT_WORDS = 4;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] arg;
    logic [7:0] len;
  } cmd_hdr_t;

  function automatic logic [2:0] beat_words(input logic [7:0] remaining);
    return (remaining >= 8'(BEAT_WORDS)) ? 3'(BEAT_WORDS) : remaining[2:0];
  endfunction

endpackage

// File: rtl/cmd_hdr_decode.sv
// Combinational header split plus the address-range and length checks
// that steer the cmd_fetch FSM out of its HDR state.
module cmd_hdr_decode
  import cmd_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 43,
  parameter int MAX_LEN   = 16
) (
  input  logic [31:0] header,
  input  logic [31:0] pc,
  output logic [7:0]  opcode,
  output logic [7:0]  arg,
  output logic [7:0]  len,
  output logic        is_halt,
  output logic        pc_fault,
  output logic        len_fault
);

  logic       has_payload;
  logic [7:0] field;

  assign has_payload = header[HDR_PAYLOAD_BIT];
  assign field       = header[FIELD_MSB:FIELD_LSB];

  // The shared [15:8] field is a length or an immediate, never both.
  assign opcode = header[OPCODE_MSB:OPCODE_LSB];
  assign arg    = has_payload ? 8'd0 : field;
  assign len    = has_payload ? field : 8'd0;

  assign is_halt   = (header == HALT_WORD);
  assign pc_fault  = (pc >= 32'(MEM_DEPTH));
  assign len_fault = has_payload && ((field == 8'd0) || (field > 8'(MAX_LEN)));

endmodule

// File: rtl/cmd_fetch.sv
// Command fetch/parse front end: walks the instruction BRAM from start_pc and
// emits header and payload-beat handshakes. Optional macro: CMD_COUNT_EN.
module cmd_fetch
  import cmd_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 43,
  parameter int MAX_LEN   = 16
) (
  input  logic         BRAM_clk,
  input  logic         BRAM_rst,
  input  logic         start,
  input  logic [31:0]  start_pc,
  output logic [31:0]  addr1,
  output logic [31:0]  addr2,
  input  logic [31:0]  read0,
  input  logic [31:0]  read1,
  input  logic [31:0]  read2,
  input  logic [31:0]  read3,
  input  logic [31:0]  read4,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [7:0]   cmd_opcode,
  output logic [7:0]   cmd_arg,
  output logic [7:0]   cmd_len,
  output logic         pay_valid,
  input  logic         pay_ready,
  output logic [127:0] pay_data,
  output logic [2:0]   pay_cnt,
  output logic         pay_last,
  output logic         busy,
  output logic         halted,
  output logic         err
`ifdef CMD_COUNT_EN
  ,
  output logic [15:0]  cmd_count
`endif
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] ptr;
  logic [7:0]  remaining;
  cmd_hdr_t    hdr_q;

  logic [7:0]  dec_opcode;
  logic [7:0]  dec_arg;
  logic [7:0]  dec_len;
  logic        dec_halt;
  logic        dec_pc_fault;
  logic        dec_len_fault;
  logic        hdr_ok;

  logic [2:0]   beat_cnt;
  logic [31:0]  beat_end;
  logic         beat_fault;
  logic         beat_last;
  logic [127:0] window;

  logic start_ok;
  logic cmd_fire;
  logic pay_fire;

  cmd_hdr_decode #(
    .MEM_DEPTH (MEM_DEPTH),
    .MAX_LEN   (MAX_LEN)
  ) u_hdr_decode (
    .header    (read0),
    .pc        (pc),
    .opcode    (dec_opcode),
    .arg       (dec_arg),
    .len       (dec_len),
    .is_halt   (dec_halt),
    .pc_fault  (dec_pc_fault),
    .len_fault (dec_len_fault)
  );

  assign hdr_ok   = !dec_pc_fault && !dec_halt && !dec_len_fault;
  assign start_ok = start && ((state == IDLE) || (state == HALT) || (state == ERR));
  assign cmd_fire = (state == CMD) && cmd_ready;

  // Range check is on the last word of the beat; 32-bit wrap is not detected.
  assign beat_cnt   = beat_words(remaining);
  assign beat_end   = ptr + 32'(beat_cnt) - 32'd1;
  assign beat_fault = (beat_end >= 32'(MEM_DEPTH));
  assign beat_last  = (remaining <= 8'(BEAT_WORDS));
  assign pay_fire   = (state == PAY) && !beat_fault && pay_ready;

  assign window = {read4, read3, read2, read1};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge BRAM_clk) begin
    if (BRAM_rst) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (start_ok) begin
      state_next = HDR;
    end else begin
      case (state)
        HDR: begin
          if      (dec_pc_fault)  state_next = ERR;
          else if (dec_halt)      state_next = HALT;
          else if (dec_len_fault) state_next = ERR;
          else                    state_next = CMD;
        end
        CMD: begin
          if (cmd_ready) state_next = (hdr_q.len == 8'd0) ? HDR : PAY;
        end
        PAY: begin
          if      (beat_fault)             state_next = ERR;
          else if (pay_ready && beat_last) state_next = HDR;
        end
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    pay_valid = 1'b0;
    pay_cnt   = 3'd0;
    pay_last  = 1'b0;
    pay_data  = '0;
    busy      = (state == HDR) || (state == CMD) || (state == PAY);
    halted    = (state == HALT);
    err       = (state == ERR);
    case (state)
      CMD: cmd_valid = 1'b1;
      PAY: begin
        pay_valid = !beat_fault;
        pay_cnt   = beat_cnt;
        pay_last  = beat_last;
        for (int k = 0; k < BEAT_WORDS; k++) begin
          if (k < int'(beat_cnt)) pay_data[32*k +: 32] = window[32*k +: 32];
        end
      end
      default: ;
    endcase
  end

  // pc tracks the next header; ptr tracks the payload window base.
  always_ff @(posedge BRAM_clk) begin
    if (BRAM_rst) begin
      pc        <= '0;
      ptr       <= '0;
      remaining <= '0;
      hdr_q     <= '0;
    end else begin
      if (start_ok) pc <= start_pc;
      case (state)
        HDR: begin
          if (hdr_ok) hdr_q <= '{opcode: dec_opcode, arg: dec_arg, len: dec_len};
        end
        CMD: begin
          if (cmd_fire) begin
            if (hdr_q.len == 8'd0) begin
              pc <= pc + 32'd1;
            end else begin
              ptr       <= pc + 32'd1;
              remaining <= hdr_q.len;
            end
          end
        end
        PAY: begin
          if (beat_fault) begin
            pc <= beat_end;
          end else if (pay_fire) begin
            ptr       <= ptr + 32'(beat_cnt);
            remaining <= remaining - 8'(beat_cnt);
            if (beat_last) pc <= ptr + 32'(beat_cnt);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMD_COUNT_EN
  // Saturates so very long programs read as "at least 65535".
  always_ff @(posedge BRAM_clk) begin
    if (BRAM_rst || start_ok) begin
      cmd_count <= '0;
    end else if (cmd_fire && (cmd_count != 16'hFFFF)) begin
      cmd_count <= cmd_count + 16'd1;
    end
  end
`endif

  assign addr1      = pc;
  assign addr2      = ptr;
  assign cmd_opcode = hdr_q.opcode;
  assign cmd_arg    = hdr_q.arg;
  assign cmd_len    = hdr_q.len;

endmodule

// File: tb/tb_cmd_fetch.sv
// Randomized self-checking bench for cmd_fetch against a program-walking
// reference model of the instruction stream (honours CMD_COUNT_EN).
module tb_cmd_fetch;
  import cmd_fetch_pkg::*;

  localparam int MEM_DEPTH = 43;
  localparam int MAX_LEN   = 16;
  localparam int MEM_SLOTS = 64;

  logic         BRAM_clk = 1'b0;
  logic         BRAM_rst;
  logic         start;
  logic [31:0]  start_pc;
  logic [31:0]  addr1, addr2;
  logic [31:0]  read0, read1, read2, read3, read4;
  logic         cmd_valid, cmd_ready;
  logic [7:0]   cmd_opcode, cmd_arg, cmd_len;
  logic         pay_valid, pay_ready;
  logic [127:0] pay_data;
  logic [2:0]   pay_cnt;
  logic         pay_last, busy, halted, err;
`ifdef CMD_COUNT_EN
  logic [15:0]  cmd_count;
`endif

  cmd_fetch #(.MEM_DEPTH(MEM_DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .BRAM_clk   (BRAM_clk),
    .BRAM_rst   (BRAM_rst),
    .start      (start),
    .start_pc   (start_pc),
    .addr1      (addr1),
    .addr2      (addr2),
    .read0      (read0),
    .read1      (read1),
    .read2      (read2),
    .read3      (read3),
    .read4      (read4),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_arg    (cmd_arg),
    .cmd_len    (cmd_len),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .pay_data   (pay_data),
    .pay_cnt    (pay_cnt),
    .pay_last   (pay_last),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
`ifdef CMD_COUNT_EN
    ,
    .cmd_count  (cmd_count)
`endif
  );

  always #5 BRAM_clk = ~BRAM_clk;

  // Asynchronous-read BRAM model; out-of-range words read as garbage.
  logic [31:0] mem [MEM_SLOTS];
  logic [31:0] a2p1, a2p2, a2p3;
  assign a2p1  = addr2 + 32'd1;
  assign a2p2  = addr2 + 32'd2;
  assign a2p3  = addr2 + 32'd3;
  assign read0 = (addr1 < MEM_SLOTS) ? mem[addr1[5:0]] : 32'hBADC_0DE5;
  assign read1 = (addr2 < MEM_SLOTS) ? mem[addr2[5:0]] : 32'hBADC_0DE5;
  assign read2 = (a2p1 < MEM_SLOTS)  ? mem[a2p1[5:0]]  : 32'hBADC_0DE5;
  assign read3 = (a2p2 < MEM_SLOTS)  ? mem[a2p2[5:0]]  : 32'hBADC_0DE5;
  assign read4 = (a2p3 < MEM_SLOTS)  ? mem[a2p3[5:0]]  : 32'hBADC_0DE5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit           is_beat;
    logic [7:0]   op;
    logic [7:0]   arg;
    logic [7:0]   len;
    logic [127:0] data;
    logic [2:0]   cnt;
    bit           last;
  } item_t;

  item_t exp_q[$];

  function automatic logic [31:0] hdr(input bit pay, input logic [7:0] fld, input logic [7:0] op);
    return {pay, 15'd0, fld, op};
  endfunction

  // Triangle image: mode, 4x4 matrix, then three colour/vertex pairs, halt at 42.
  task automatic load_image();
    for (int i = 0; i < MEM_SLOTS; i++) mem[i] = (i < MEM_DEPTH) ? 32'h0 : (32'hDEAD_0000 | 32'(i));
    mem[0]  = hdr(1'b0, 8'd1, OP_MATRIX_MODE);
    mem[1]  = hdr(1'b1, 8'd16, OP_MULT_MATRIX);
    mem[2]  = 32'h3B4C_CCCD;
    mem[7]  = 32'h3B4C_CCCD;
    mem[12] = 32'h3C23_D70A;
    mem[17] = 32'h3F80_0000;
    mem[18] = hdr(1'b1, 8'd3, OP_COLOR);
    mem[19] = 32'h3F80_0000;
    mem[22] = hdr(1'b1, 8'd3, OP_VERTEX);
    mem[23] = 32'h3F80_0000;
    mem[24] = 32'h42C8_0000;
    mem[26] = hdr(1'b1, 8'd3, OP_COLOR);
    mem[28] = 32'h3F80_0000;
    mem[30] = hdr(1'b1, 8'd3, OP_VERTEX);
    mem[31] = 32'h42C8_0000;
    mem[32] = 32'h42C8_0000;
    mem[34] = hdr(1'b1, 8'd3, OP_COLOR);
    mem[37] = 32'h3F80_0000;
    mem[38] = hdr(1'b1, 8'd3, OP_VERTEX);
    mem[39] = 32'h42C8_0000;
    mem[40] = 32'h3F80_0000;
    mem[42] = 32'h0;
  endtask

  // Walks the program as the command stream is defined, producing the
  // ordered list of headers and beats plus the terminal status.
  task automatic build_model(input logic [31:0] spc, output bit exp_halt,
                             output logic [31:0] exp_pc, output bit chk_pc, output int n_cmd);
    logic [31:0] pc, ptr, h;
    int          rem, c;
    item_t       it;
    bit          done;
    exp_q.delete();
    n_cmd = 0; pc = spc; done = 0; chk_pc = 1; exp_halt = 0; exp_pc = spc;
    while (!done) begin
      if (pc >= 32'(MEM_DEPTH)) begin
        done = 1; exp_pc = pc;
      end else begin
        h = mem[pc[5:0]];
        if (h == 32'h0) begin
          done = 1; exp_halt = 1; exp_pc = pc;
        end else if (h[31] && (h[15:8] == 8'd0 || h[15:8] > 8'(MAX_LEN))) begin
          done = 1; exp_pc = pc;
        end else begin
          it = '{default: '0};
          it.op  = h[7:0];
          it.arg = h[31] ? 8'd0 : h[15:8];
          it.len = h[31] ? h[15:8] : 8'd0;
          exp_q.push_back(it);
          n_cmd++;
          if (!h[31]) begin
            pc = pc + 32'd1;
          end else begin
            ptr = pc + 32'd1;
            rem = int'(h[15:8]);
            while (rem > 0 && !done) begin
              c = (rem < 4) ? rem : 4;
              if (ptr + 32'(c) - 32'd1 >= 32'(MEM_DEPTH)) begin
                done = 1; chk_pc = 0;
              end else begin
                it = '{default: '0};
                it.is_beat = 1;
                for (int w = 0; w < c; w++) it.data[32*w +: 32] = mem[ptr[5:0] + 6'(w)];
                it.cnt  = 3'(c);
                it.last = (rem <= 4);
                exp_q.push_back(it);
                ptr = ptr + 32'(c);
                rem = rem - c;
              end
            end
            pc = ptr;
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {cmd_valid, pay_valid, pay_cnt, pay_last, busy, halted, err}, '0);
    check({tag, "_addrs"}, {addr1, addr2}, '0);
    check({tag, "_cmd_fields"}, {cmd_opcode, cmd_arg, cmd_len}, '0);
    check({tag, "_pay_data"}, pay_data, '0);
`ifdef CMD_COUNT_EN
    check({tag, "_cmd_count"}, cmd_count, '0);
`endif
  endtask

  task automatic run_program(input logic [31:0] spc, input int stall_pct,
                             input string name, output int seen_cmd);
    bit           exp_halt, chk_pc, done, cmd_hold, pay_hold;
    logic [31:0]  exp_pc;
    int           n_cmd, cyc;
    item_t        head;
    logic [23:0]  cmd_snap;
    logic [127:0] pay_snap;
    logic [4:0]   pay_ctl_snap;
    build_model(spc, exp_halt, exp_pc, chk_pc, n_cmd);
    @(negedge BRAM_clk);
    start = 1'b1; start_pc = spc; cmd_ready = 1'b0; pay_ready = 1'b0;
    @(negedge BRAM_clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1'b1);
    check({name, "_no_early_cmd"}, cmd_valid, 1'b0);
`ifdef CMD_COUNT_EN
    check({name, "_count_cleared"}, cmd_count, 16'd0);
`endif
    @(negedge BRAM_clk);
    check({name, "_hdr_latency"}, cmd_valid, exp_q.size() > 0);
    cmd_hold = 0; pay_hold = 0; done = 0; cyc = 0; seen_cmd = 0;
    cmd_snap = '0; pay_snap = '0; pay_ctl_snap = '0;
    while (!done && cyc < 3000) begin
      if (cmd_hold) check({name, "_cmd_stable"}, {cmd_valid, cmd_opcode, cmd_arg, cmd_len}, {1'b1, cmd_snap});
      if (pay_hold) begin
        check({name, "_pay_data_stable"}, pay_data, pay_snap);
        check({name, "_pay_ctl_stable"}, {pay_valid, pay_cnt, pay_last}, pay_ctl_snap);
      end
      if (halted || err) begin
        done = 1;
      end else begin
        cmd_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
        pay_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
        start     = busy && ($urandom_range(0, 7) == 0);
        start_pc  = $urandom;
        if (cmd_valid && cmd_ready) begin
          seen_cmd++;
          check({name, "_cmd_expected"}, exp_q.size() > 0 && !exp_q[0].is_beat, 1'b1);
          if (exp_q.size() > 0 && !exp_q[0].is_beat) begin
            head = exp_q.pop_front();
            check({name, "_cmd_fields"}, {cmd_opcode, cmd_arg, cmd_len}, {head.op, head.arg, head.len});
          end
        end
        if (pay_valid && pay_ready) begin
          check({name, "_beat_expected"}, exp_q.size() > 0 && exp_q[0].is_beat, 1'b1);
          if (exp_q.size() > 0 && exp_q[0].is_beat) begin
            head = exp_q.pop_front();
            check({name, "_pay_data"}, pay_data, head.data);
            check({name, "_pay_cnt_last"}, {pay_cnt, pay_last}, {head.cnt, head.last});
          end
        end
        cmd_hold     = cmd_valid && !cmd_ready;
        cmd_snap     = {cmd_opcode, cmd_arg, cmd_len};
        pay_hold     = pay_valid && !pay_ready;
        pay_snap     = pay_data;
        pay_ctl_snap = {1'b1, pay_cnt, pay_last};
        @(negedge BRAM_clk);
        cyc++;
      end
    end
    start = 1'b0; cmd_ready = 1'b0; pay_ready = 1'b0;
    check({name, "_finished_in_budget"}, done, 1'b1);
    check({name, "_status"}, {halted, err, busy}, {exp_halt, !exp_halt, 1'b0});
    check({name, "_stream_drained"}, exp_q.size(), 0);
    check({name, "_cmd_total"}, seen_cmd, n_cmd);
    if (chk_pc) check({name, "_final_pc"}, addr1, exp_pc);
`ifdef CMD_COUNT_EN
    check({name, "_cmd_count"}, cmd_count, n_cmd);
`endif
  endtask

  task automatic reset_mid_beat();
    int pay_hs, cyc;
    bit hit;
    pay_hs = 0; cyc = 0; hit = 0;
    @(negedge BRAM_clk);
    start = 1'b1; start_pc = 32'd0; cmd_ready = 1'b1; pay_ready = 1'b1;
    @(negedge BRAM_clk);
    start = 1'b0;
    while (!hit && cyc < 200) begin
      if (pay_valid && pay_hs == 1) begin
        BRAM_rst = 1'b1;
        hit = 1;
      end else begin
        if (pay_valid) pay_hs++;
        @(negedge BRAM_clk);
        cyc++;
      end
    end
    check("rst_reached_second_beat", hit, 1'b1);
    @(negedge BRAM_clk);
    check_reset_outputs("rst_mid_cmd");
    BRAM_rst = 1'b0; cmd_ready = 1'b0; pay_ready = 1'b0;
    @(negedge BRAM_clk);
    check("rst_stays_idle", {cmd_valid, pay_valid, busy, halted, err}, '0);
  endtask

  initial begin
    int seen;
    BRAM_rst = 1'b1; start = 1'b0; start_pc = '0; cmd_ready = 1'b0; pay_ready = 1'b0;
    load_image();
    repeat (3) @(negedge BRAM_clk);
    check_reset_outputs("por");
    BRAM_rst = 1'b0;

    run_program(32'd0, 0, "nostall", seen);
    check("nostall_eight_headers", seen, 8);
    run_program(32'd0, 40, "stall40", seen);
    check("stall40_eight_headers", seen, 8);
    run_program(32'd18, 25, "pc18", seen);
    for (int i = 0; i < 4; i++) begin
      run_program(32'($urandom_range(0, 47)), $urandom_range(0, 60), "rand", seen);
    end

    run_program(32'd43, 0, "pc43", seen);

    mem[0] = 32'h8000_1411;
    run_program(32'd0, 0, "badlen", seen);
    load_image();

    mem[40] = hdr(1'b1, 8'd4, OP_VERTEX);
    run_program(32'd40, 20, "crossing", seen);
    load_image();

    reset_mid_beat();
    run_program(32'd0, 0, "replay", seen);
    check("replay_eight_headers", seen, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
